// File: rtl/odd_even_sort_pkg.sv
// Shared types and constants for the odd-even transposition sorter.
//   state_t    : sorter control states (IDLE -> SORT -> DONE)
//   PHASE_EVEN : parity of the phase counter for pairs (0,1),(2,3),...
//   PHASE_ODD  : parity of the phase counter for pairs (1,2),(3,4),...
package odd_even_sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic PHASE_EVEN = 1'b0;
  localparam logic PHASE_ODD  = 1'b1;

endpackage

// File: rtl/odd_even_cmp_swap.sv
// Single compare-exchange cell.
//   a, b    : inputs; a belongs to the lower array index
//   descend : 0 = smaller value to lo, 1 = larger value to lo
//   lo, hi  : outputs for the lower / higher array index
// Swaps only when the pair is strictly out of order, so equal values
// pass straight through.
module odd_even_cmp_swap #(
  parameter int W      = 16,
  parameter int SIGNED = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         descend,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         swap;

  // Steer the operands so one "x > y" comparator covers both orders:
  // ascending swaps when a > b, descending swaps when b > a.
  assign x = descend ? b : a;
  assign y = descend ? a : b;

  generate
    if (SIGNED != 0) begin : g_signed
      assign swap = $signed(x) > $signed(y);
    end else begin : g_unsigned
      assign swap = x > y;
    end
  endgenerate

  assign lo = swap ? b : a;
  assign hi = swap ? a : b;

endmodule

// File: rtl/odd_even_sorter.sv
// Multi-cycle odd-even transposition sorter for a set of N W-bit elements.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake; a set is accepted in IDLE only
//   in_data, descend     : unsorted set (element k at [k*W +: W]) and order
//   out_valid/out_ready  : output handshake; out_valid held in DONE
//   out_data             : sorted set, same packing, updated on entry to DONE
// One transposition phase runs per clock; N phases fully sort N elements.
module odd_even_sorter
  import odd_even_sort_pkg::*;
#(
  parameter int N      = 5,
  parameter int W      = 16,
  parameter int SIGNED = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           descend,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data
);

  // Counter reaches N after the last phase, hence N+1 distinct values.
  localparam int PW = $clog2(N + 1);

  state_t                state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [N-1:0][W-1:0]   work_q, work_d;
  logic [N-1:0][W-1:0]   out_data_q, out_data_d;
  logic                  descend_q, descend_d;
  logic                  out_valid_q, out_valid_d;

  // Results of one even phase and one odd phase on the current array.
  logic [W-1:0] even_arr [N];
  logic [W-1:0] odd_arr  [N];

  genvar gi;
  generate
    for (gi = 0; gi < N / 2; gi++) begin : g_even
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      odd_even_cmp_swap #(.W(W), .SIGNED(SIGNED)) u_cs (
        .a       (work_q[2*gi]),
        .b       (work_q[2*gi+1]),
        .descend (descend_q),
        .lo      (lo),
        .hi      (hi)
      );
      assign even_arr[2*gi]   = lo;
      assign even_arr[2*gi+1] = hi;
    end
    if (N % 2 != 0) begin : g_even_tail
      assign even_arr[N-1] = work_q[N-1];
    end

    for (gi = 0; gi < (N - 1) / 2; gi++) begin : g_odd
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      odd_even_cmp_swap #(.W(W), .SIGNED(SIGNED)) u_cs (
        .a       (work_q[2*gi+1]),
        .b       (work_q[2*gi+2]),
        .descend (descend_q),
        .lo      (lo),
        .hi      (hi)
      );
      assign odd_arr[2*gi+1] = lo;
      assign odd_arr[2*gi+2] = hi;
    end
    assign odd_arr[0] = work_q[0];
    if (N % 2 == 0) begin : g_odd_tail
      assign odd_arr[N-1] = work_q[N-1];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    work_d      = work_q;
    descend_d   = descend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d    = in_data;
          descend_d = descend;
          phase_d   = '0;
          state_d   = SORT;
        end
      end
      SORT: begin
        for (int k = 0; k < N; k++) begin
          work_d[k] = (phase_q[0] == PHASE_EVEN) ? even_arr[k] : odd_arr[k];
        end
        phase_d = phase_q + PW'(1);
        if (phase_q == PW'(N - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_data_d  = work_d;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      work_q      <= '0;
      out_data_q  <= '0;
      descend_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      work_q      <= work_d;
      out_data_q  <= out_data_d;
      descend_q   <= descend_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: doc/odd_even_sorter.md
ODD_EVEN_SORTER -- requirements
Module: odd_even_sorter

Interface
REQ-001 SHALL have parameter N, default 5, number of elements per set (legal N >= 2).
REQ-002 SHALL have parameter W, default 16, element width in bits.
REQ-003 SHALL have parameter SIGNED, default 0; 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  input set present.
REQ-007 SHALL have port in_ready  output  1  block can accept a set.
REQ-008 SHALL have port in_data  input  N*W  unsorted set; element k occupies bits [k*W +: W].
REQ-009 SHALL have port descend  input  1  sort order: 0 = ascending, 1 = descending; sampled with in_data.
REQ-010 SHALL have port out_valid  output  1  sorted set present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the sorted set.
REQ-012 SHALL have port out_data  output  N*W  sorted set, same packing; ascending means element 0 is smallest.

Function
REQ-013 SHALL implement FSM states IDLE, SORT, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; on in_valid && in_ready, SHALL register in_data into the working array, latch descend, clear phase counter to 0, and enter SORT.
REQ-015 In SORT, each clock SHALL execute exactly one odd-even transposition phase on the registered array, then increment the phase counter.
REQ-016 Even phase (counter even) SHALL compare-exchange pairs (0,1),(2,3),...; odd phase SHALL compare-exchange pairs (1,2),(3,4),...; unpaired end element SHALL pass unchanged.
REQ-017 Compare-exchange SHALL swap only when strictly out of order; equal elements are never swapped.
REQ-018 After phase N-1 executes, FSM SHALL enter DONE; out_valid SHALL rise exactly N edges after the accepting edge.
REQ-019 In DONE, out_valid SHALL be 1 and out_data SHALL be stable until out_valid && out_ready; that edge SHALL return to IDLE and clear out_valid.
REQ-020 in_ready SHALL be 0 in SORT and DONE; no overlap between sets; peak throughput one set per N+2 cycles.
REQ-021 Changes on in_data, in_valid or descend outside the accepting edge SHALL NOT affect a set in flight.
REQ-022 out_data SHALL hold its last value in IDLE and SORT and SHALL only update on entry to DONE.
REQ-023 Phase counter SHALL be ceil(log2(N+1)) bits and SHALL NOT wrap during a sort.

Reset
REQ-024 rst high at a clock edge SHALL force IDLE, phase counter 0, out_valid 0, out_data 0, working array 0, latched descend 0.
REQ-025 in_ready SHALL be 0 while rst is high and 1 on the first cycle after rst deasserts.
REQ-026 Reset in SORT or DONE SHALL abandon the set; no out_valid pulse for it.

Structure
REQ-027 Shared package odd_even_sort_pkg SHALL hold the FSM state type and the phase-parity constants.
REQ-028 Compare-exchange SHALL be one sub-module, odd_even_cmp_swap (params W, SIGNED; inputs a, b, descend; outputs lo, hi), instantiated per pair for even and odd phases.
REQ-029 Datapath SHALL use one W-bit comparator per cmp_swap instance; no multi-cycle paths.

Verification (N=5, W=16 unless stated)
REQ-030 Ascending {5,4,3,2,1}, descend=0 -> out_data {1,2,3,4,5}, out_valid 5 edges after accept, out_ready=1 returns IDLE next edge.
REQ-031 {3,9,1,9,0}, descend=1 -> {9,9,3,1,0}; duplicates preserved, count of each value unchanged.
REQ-032 out_ready held 0 for 4 cycles after out_valid -> out_data stable, in_ready 0, in_valid ignored; release -> one transfer only.
REQ-033 rst pulsed at phase 2 of {5,4,3,2,1} -> out_valid never asserts; in_ready 1 one cycle after rst low; next set sorts correctly.
REQ-034 SIGNED=1, {0x0001,0xFFFF,0x8000,0x7FFF,0x0000} ascending -> {0x8000,0xFFFF,0x0000,0x0001,0x7FFF}; SIGNED=0 same input -> {0x0000,0x0001,0x7FFF,0x8000,0xFFFF}.
REQ-035 N=2 {7,2} and N=8 random back-to-back sets -> sorted vs. reference model, out_valid at N edges after each accept.
